// File: rtl/run_sequencer.sv
// Run-level controller for the processor core: accepts a program-start request,
// holds the core in reset for a fixed window, then times the run until done or watchdog.
module run_sequencer #(
    parameter int             D       = 12,
    parameter int             CW      = 16,
    parameter int             RST_CYC = 2,
    parameter int             TIMEOUT = 4096,
    parameter logic [D-1:0]   PC0     = 12'h000,
    parameter logic [D-1:0]   PC1     = 12'h100,
    parameter logic [D-1:0]   PC2     = 12'h200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [1:0]    prog_sel,
    input  logic          core_done,
    output logic          core_reset,
    output logic [D-1:0]  start_pc,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          bad_sel,
    output logic [CW-1:0] cycle_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [3:0]    RST_LOAD  = 4'(RST_CYC - 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] sel_q;
    logic [3:0] rst_cnt;
    logic       idle_or_fin;
    logic       legal_req;

    assign idle_or_fin = (state == S_IDLE) || (state == S_FIN);
    assign legal_req   = idle_or_fin && req && (prog_sel != 2'd3);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sel_q       <= 2'd0;
            rst_cnt     <= 4'd0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            bad_sel     <= 1'b0;
        end else begin
            bad_sel <= idle_or_fin && req && (prog_sel == 2'd3);
            case (state)
                S_IDLE, S_FIN: begin
                    if (legal_req) begin
                        sel_q       <= prog_sel;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        rst_cnt     <= RST_LOAD;
                        state       <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt == 4'd0) state <= S_RUN;
                    else                 rst_cnt <= rst_cnt - 4'd1;
                end
                S_RUN: begin
                    cycle_count <= cycle_count + CW'(1);
                    // core_done takes priority over a watchdog expiring on the same edge
                    if (core_done) begin
                        state   <= S_FIN;
                        timeout <= 1'b0;
                    end else if (cycle_count == WDOG_LAST) begin
                        state   <= S_FIN;
                        timeout <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_RST: busy = 1'b1;
            S_RUN: begin
                busy       = 1'b1;
                core_reset = 1'b0;
            end
            S_FIN: begin
                done       = 1'b1;
                core_reset = timeout;
            end
            default: ;
        endcase
    end

    always_comb begin
        start_pc = PC0;
        case (sel_q)
            2'd1:    start_pc = PC1;
            2'd2:    start_pc = PC2;
            default: start_pc = PC0;
        endcase
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: two instances (watchdog 8 and 16) share stimulus
// and are compared every cycle against a run-phase reference model.
module tb_run_sequencer;

    localparam int RST_CYC = 2;
    localparam int TO_A    = 8;
    localparam int TO_B    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  prog_sel;
    logic        core_done;

    logic        core_reset_o [2];
    logic [11:0] start_pc_o   [2];
    logic        busy_o       [2];
    logic        done_o       [2];
    logic        timeout_o    [2];
    logic        bad_sel_o    [2];
    logic [15:0] cnt_o        [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    run_sequencer #(.RST_CYC(RST_CYC), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .core_done(core_done),
        .core_reset(core_reset_o[0]), .start_pc(start_pc_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .timeout(timeout_o[0]), .bad_sel(bad_sel_o[0]),
        .cycle_count(cnt_o[0])
    );

    run_sequencer #(.RST_CYC(RST_CYC), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .core_done(core_done),
        .core_reset(core_reset_o[1]), .start_pc(start_pc_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .timeout(timeout_o[1]), .bad_sel(bad_sel_o[1]),
        .cycle_count(cnt_o[1])
    );

    // Reference model: a run is "active" from acceptance until it ends; m_el counts
    // cycles since acceptance, so the first RST_CYC of them are the reset window.
    logic        m_active [2];
    logic        m_fin    [2];
    logic        m_to     [2];
    logic        m_bad    [2];
    int          m_el     [2];
    int          m_cnt    [2];
    int          m_sel    [2];
    logic [11:0] pc_tab   [3] = '{12'h000, 12'h100, 12'h200};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int limit_of(input int i);
        return (i == 0) ? TO_A : TO_B;
    endfunction

    task automatic model_step(input int i);
        int k;
        if (reset) begin
            m_active[i] = 1'b0; m_fin[i] = 1'b0; m_to[i] = 1'b0; m_bad[i] = 1'b0;
            m_el[i] = 0; m_cnt[i] = 0; m_sel[i] = 0;
        end else begin
            m_bad[i] = 1'b0;
            if (!m_active[i]) begin
                if (req && prog_sel == 2'd3) m_bad[i] = 1'b1;
                else if (req) begin
                    m_sel[i] = int'(prog_sel); m_cnt[i] = 0; m_to[i] = 1'b0;
                    m_active[i] = 1'b1; m_fin[i] = 1'b0; m_el[i] = 1;
                end
            end else if (m_el[i] <= RST_CYC) begin
                m_el[i]++;
            end else begin
                k = m_el[i] - RST_CYC;
                m_cnt[i] = k;
                if (core_done) begin
                    m_active[i] = 1'b0; m_fin[i] = 1'b1; m_to[i] = 1'b0;
                end else if (k == limit_of(i)) begin
                    m_active[i] = 1'b0; m_fin[i] = 1'b1; m_to[i] = 1'b1;
                end else begin
                    m_el[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic exp_cr;
        for (int i = 0; i < 2; i++) begin
            exp_cr = m_active[i] ? (m_el[i] <= RST_CYC) : (m_fin[i] ? m_to[i] : 1'b1);
            check($sformatf("dut%0d.core_reset", i), 32'(core_reset_o[i]), 32'(exp_cr));
            check($sformatf("dut%0d.busy", i), 32'(busy_o[i]), 32'(m_active[i]));
            check($sformatf("dut%0d.done", i), 32'(done_o[i]), 32'(m_fin[i]));
            check($sformatf("dut%0d.timeout", i), 32'(timeout_o[i]), 32'(m_to[i]));
            check($sformatf("dut%0d.bad_sel", i), 32'(bad_sel_o[i]), 32'(m_bad[i]));
            check($sformatf("dut%0d.cycle_count", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
            check($sformatf("dut%0d.start_pc", i), 32'(start_pc_o[i]), 32'(pc_tab[m_sel[i]]));
        end
    endtask

    // One clock: the model steps on the inputs held across the edge, outputs checked 1ns later.
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        check_all();
    endtask

    // Accept a request, confirm the reset window, then run n_run RUN cycles with
    // core_done raised on RUN cycle done_k (0 = never).
    task automatic do_run(input logic [1:0] sel, input int done_k, input int n_run);
        req = 1'b1; prog_sel = sel;
        cycle();
        req = 1'b0;
        for (int r = 0; r < RST_CYC; r++) begin
            check("rst_window.core_reset", 32'(core_reset_o[1]), 32'd1);
            cycle();
        end
        check("run_entry.core_reset", 32'(core_reset_o[1]), 32'd0);
        for (int k = 1; k <= n_run; k++) begin
            core_done = (k == done_k);
            cycle();
        end
        core_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; prog_sel = 2'd0; core_done = 1'b0;
        repeat (2) cycle();
        check("reset.start_pc", 32'(start_pc_o[0]), 32'h000);
        check("reset.core_reset", 32'(core_reset_o[0]), 32'd1);
        reset = 1'b0;
        cycle();

        // Nominal: program 1, done on the 10th RUN cycle (instance B, watchdog 16)
        do_run(2'd1, 10, 10);
        check("nominal.done", 32'(done_o[1]), 32'd1);
        check("nominal.cycle_count", 32'(cnt_o[1]), 32'd10);
        check("nominal.timeout", 32'(timeout_o[1]), 32'd0);
        check("nominal.start_pc", 32'(start_pc_o[1]), 32'h100);

        // Watchdog: program 2, core_done never (instance A, watchdog 8)
        do_run(2'd2, 0, 8);
        check("wdog.done", 32'(done_o[0]), 32'd1);
        check("wdog.cycle_count", 32'(cnt_o[0]), 32'd8);
        check("wdog.timeout", 32'(timeout_o[0]), 32'd1);
        check("wdog.core_reset", 32'(core_reset_o[0]), 32'd1);
        check("wdog.start_pc", 32'(start_pc_o[0]), 32'h200);
        repeat (10) cycle();
        check("wdog_b.cycle_count", 32'(cnt_o[1]), 32'd16);
        check("wdog_b.timeout", 32'(timeout_o[1]), 32'd1);

        // Collision: core_done on the very edge the watchdog would fire
        do_run(2'd1, 8, 8);
        check("collide.timeout", 32'(timeout_o[0]), 32'd0);
        check("collide.cycle_count", 32'(cnt_o[0]), 32'd8);
        check("collide.done", 32'(done_o[0]), 32'd1);

        // Illegal select in FIN, then in IDLE
        req = 1'b1; prog_sel = 2'd3;
        cycle();
        req = 1'b0;
        check("bad_fin.bad_sel", 32'(bad_sel_o[0]), 32'd1);
        check("bad_fin.cycle_count", 32'(cnt_o[0]), 32'd8);
        cycle();
        check("bad_fin.pulse_end", 32'(bad_sel_o[0]), 32'd0);
        check("bad_fin.still_done", 32'(done_o[0]), 32'd1);
        reset = 1'b1; cycle(); reset = 1'b0;
        req = 1'b1; prog_sel = 2'd3;
        cycle();
        req = 1'b0;
        check("bad_idle.bad_sel", 32'(bad_sel_o[0]), 32'd1);
        check("bad_idle.busy", 32'(busy_o[0]), 32'd0);
        cycle();

        // Requests during RST and RUN are ignored
        req = 1'b1; prog_sel = 2'd2;
        cycle();
        prog_sel = 2'd3;
        cycle();
        req = 1'b0;
        cycle();
        for (int k = 1; k <= 6; k++) begin
            req = (k == 3); prog_sel = 2'd0;
            core_done = (k == 6);
            cycle();
        end
        req = 1'b0; core_done = 1'b0;
        check("ignored.cycle_count", 32'(cnt_o[0]), 32'd6);
        check("ignored.start_pc", 32'(start_pc_o[0]), 32'h200);

        // Reset on RUN cycle 5, then a run to FIN and a restart from FIN on program 0
        req = 1'b1; prog_sel = 2'd2;
        cycle();
        req = 1'b0;
        repeat (RST_CYC + 4) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst.busy", 32'(busy_o[0]), 32'd0);
        check("midrst.core_reset", 32'(core_reset_o[0]), 32'd1);
        check("midrst.cycle_count", 32'(cnt_o[0]), 32'd0);
        do_run(2'd1, 3, 3);
        req = 1'b1; prog_sel = 2'd0;
        cycle();
        req = 1'b0;
        check("restart.start_pc", 32'(start_pc_o[0]), 32'h000);
        check("restart.cycle_count", 32'(cnt_o[0]), 32'd0);
        repeat (RST_CYC + 1) cycle();
        check("restart.counting", 32'(cnt_o[0]), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req       = ($urandom_range(0, 5) == 0);
            prog_sel  = 2'($urandom_range(0, 3));
            core_done = ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
